// File: rtl/mem_stage.sv
// mem_stage -- RV32I memory-access pipeline stage.
//
// Takes the EX/MEM pipeline register, issues a single held request to a
// memory port for loads/stores, stalls the pipeline while the access is in
// flight, and produces the MEM/WB pipeline register.
//
// Ports:
//   clk, Rst            single clock, synchronous active-high reset
//   dbg                 debug freeze: no new request, no MEM_WB update
//   EX_MEM_*            incoming pipeline register (address/result, store
//                       data, memread/memwrite, funct3, rd, regwrite)
//   mem_req/we/addr/    memory request, held stable until mem_ack
//   mem_wdata/mem_be
//   mem_rdata/mem_ack   load data and one-cycle completion strobe
//   mem_hold            stall to all pipeline stages (combinational)
//   mem_fault           one-cycle pulse: illegal access or timeout
//   MEM_WB_*            registered result, extended load data, controls
//
// mem_stage_lane is the per-byte-lane store steering slice (data + enable).

module mem_stage_lane #(
  parameter int LANE  = 0,
  parameter int VEC_W = 8
) (
  input  logic [1:0]       size,      // funct3[1:0]: 0 byte, 1 half, 2 word
  input  logic [1:0]       off,       // byte offset within the word
  input  logic [VEC_W-1:0] byte_src,  // store byte 0 (byte replication)
  input  logic [VEC_W-1:0] half_src,  // store half byte for this lane parity
  input  logic [VEC_W-1:0] word_src,  // store byte at this lane position
  output logic [VEC_W-1:0] wbyte,
  output logic             be
);
  localparam logic [1:0] LN = 2'(LANE);

  always_comb begin
    case (size)
      2'b00: begin
        wbyte = byte_src;
        be    = (off == LN);
      end
      2'b01: begin
        wbyte = half_src;
        be    = (off[1] == LN[1]);
      end
      default: begin
        wbyte = word_src;
        be    = 1'b1;
      end
    endcase
  end
endmodule

module mem_stage #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_wdata,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_regwrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_hold,
  output logic        mem_fault,
  output logic [31:0] MEM_WB_alures,
  output logic [31:0] MEM_WB_memres,
  output logic        MEM_WB_memread,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  // last BUSY cycle index before the access is abandoned
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] buf_res;
  logic        buf_kill;

  // ---------------- request decode ----------------
  logic acc, legal, size_ok, align_ok, tmo;

  always_comb begin
    acc = EX_MEM_memread | EX_MEM_memwrite;
    case (EX_MEM_funct3)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~EX_MEM_memwrite;  // unsigned forms are load-only
      default:                size_ok = 1'b0;
    endcase
    case (EX_MEM_funct3[1:0])
      2'b01:   align_ok = ~EX_MEM_alures[0];
      2'b10:   align_ok = (EX_MEM_alures[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = size_ok & align_ok & ~(EX_MEM_memread & EX_MEM_memwrite);
  end

  assign tmo = (cnt == TMO_LAST);

  // ---------------- store lane steering ----------------
  logic [NUM_LANES-1:0][VEC_W-1:0] st_lane;
  logic [NUM_LANES-1:0]            st_be;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_stage_lane #(.LANE(i), .VEC_W(VEC_W)) u_lane (
      .size     (EX_MEM_funct3[1:0]),
      .off      (EX_MEM_alures[1:0]),
      .byte_src (EX_MEM_wdata[VEC_W-1:0]),
      .half_src (EX_MEM_wdata[VEC_W*(i%2) +: VEC_W]),
      .word_src (EX_MEM_wdata[VEC_W*i +: VEC_W]),
      .wbyte    (st_lane[i]),
      .be       (st_be[i])
    );
  end

  // ---------------- load extension ----------------
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  always_comb begin
    ld_b = mem_rdata[{off_q, 3'b000} +: 8];
    ld_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'd0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'd0, ld_h};
      default: ld_ext = mem_rdata;
    endcase
    if (mem_we) ld_ext = '0;  // stores carry no load result
  end

  // ---------------- control ----------------
  logic        issue, fault_nxt, wb_en, wb_kill, buf_en;
  logic [31:0] wb_res;

  always_comb begin
    state_nxt = state;
    mem_hold  = 1'b0;
    issue     = 1'b0;
    fault_nxt = 1'b0;
    wb_en     = 1'b0;
    wb_kill   = 1'b0;
    wb_res    = '0;
    buf_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!dbg) begin
          if (!acc) begin
            wb_en = 1'b1;
          end else if (legal) begin
            issue     = 1'b1;
            mem_hold  = 1'b1;
            state_nxt = BUSY;
          end else begin
            wb_en     = 1'b1;
            wb_kill   = 1'b1;
            fault_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ack || tmo) begin
          // ack wins over a coincident timeout
          fault_nxt = ~mem_ack;
          if (dbg) begin
            // completion parked until the freeze lifts; keep the pipe held
            buf_en    = 1'b1;
            mem_hold  = 1'b1;
            state_nxt = DONE;
          end else begin
            // release the stall so the finished (or aborted) op retires
            wb_en     = 1'b1;
            wb_kill   = ~mem_ack;
            wb_res    = mem_ack ? ld_ext : '0;
            state_nxt = IDLE;
          end
        end else begin
          mem_hold = 1'b1;
        end
      end
      DONE: begin
        if (dbg) begin
          mem_hold = 1'b1;
        end else begin
          wb_en     = 1'b1;
          wb_kill   = buf_kill;
          wb_res    = buf_res;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (Rst) mem_hold = 1'b0;
  end

  assign mem_req = (state == BUSY);

  always_ff @(posedge clk) begin
    if (Rst) begin
      state           <= IDLE;
      cnt             <= '0;
      mem_fault       <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_be          <= '0;
      off_q           <= '0;
      f3_q            <= '0;
      buf_res         <= '0;
      buf_kill        <= 1'b0;
      MEM_WB_alures   <= '0;
      MEM_WB_memres   <= '0;
      MEM_WB_memread  <= 1'b0;
      MEM_WB_rd       <= '0;
      MEM_WB_regwrite <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_fault <= fault_nxt;
      if (issue) begin
        cnt       <= '0;
        mem_we    <= EX_MEM_memwrite;
        mem_addr  <= {EX_MEM_alures[31:2], 2'b00};
        mem_wdata <= EX_MEM_memwrite ? st_lane : '0;
        mem_be    <= EX_MEM_memwrite ? st_be : '0;
        off_q     <= EX_MEM_alures[1:0];
        f3_q      <= EX_MEM_funct3;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
      if (buf_en) begin
        buf_res  <= mem_ack ? ld_ext : '0;
        buf_kill <= ~mem_ack;
      end
      if (wb_en) begin
        MEM_WB_alures   <= EX_MEM_alures;
        MEM_WB_memres   <= wb_res;
        MEM_WB_memread  <= EX_MEM_memread & ~wb_kill;
        MEM_WB_rd       <= EX_MEM_rd;
        MEM_WB_regwrite <= EX_MEM_regwrite & ~wb_kill;
      end
    end
  end
endmodule
